// File: rtl/cmd_tag_pool_ctrl.sv
// Free-list tag pool shared by several command producers: round-robin allocation,
// release on PSL response, and paged-fault flush / restart / replay sequencing.
module cmd_tag_pool_ctrl #(
  parameter int unsigned  TAG_COUNT    = 32,
  parameter int unsigned  NUM_CHANNELS = 4,
  localparam int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] alloc_req,
  output logic [NUM_CHANNELS-1:0] alloc_grant,
  output logic [7:0]              alloc_tag,
  input  logic                    rsp_valid,
  input  logic [7:0]              rsp_tag,
  input  logic [1:0]              rsp_code,
  output logic                    restart_req,
  input  logic                    restart_ack,
  output logic                    replay_valid,
  input  logic                    replay_ready,
  output logic [7:0]              replay_tag,
  output logic [CH_W-1:0]         replay_ch,
  output logic                    pool_ready,
  output logic [8:0]              free_count,
  output logic                    error_flag,
  output logic [7:0]              error_tag
);

  localparam int unsigned TAG_W = $clog2(TAG_COUNT);
  localparam int unsigned CNT_W = 9;

  localparam logic [1:0] RSP_DONE    = 2'b00;
  localparam logic [1:0] RSP_FLUSHED = 2'b01;
  localparam logic [1:0] RSP_PAGED   = 2'b10;
  localparam logic [1:0] RSP_ERROR   = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT, ST_READY, ST_FLUSH, ST_RESTART, ST_REPLAY
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              fifo_q [TAG_COUNT];
  logic [7:0]              fifo_d [TAG_COUNT];
  logic [CH_W-1:0]         owner_q [TAG_COUNT];
  logic [CH_W-1:0]         owner_d [TAG_COUNT];
  logic [TAG_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]        count_q, count_d, scan_q, scan_d;
  logic [TAG_COUNT-1:0]    valid_q, valid_d, replay_q, replay_d;
  logic [CH_W-1:0]         rr_q, rr_d;
  logic [NUM_CHANNELS-1:0] alloc_grant_q, alloc_grant_d;
  logic [7:0]              alloc_tag_q, alloc_tag_d, replay_tag_q, replay_tag_d;
  logic [7:0]              error_tag_q, error_tag_d;
  logic [CH_W-1:0]         replay_ch_q, replay_ch_d;
  logic                    restart_req_q, restart_req_d, replay_valid_q, replay_valid_d;
  logic                    pool_ready_q, pool_ready_d, error_flag_q, error_flag_d;

  logic                    push, pop, rsp_ok, have_req, scan_hit;
  logic [7:0]              push_tag, pop_tag;
  logic [TAG_W-1:0]        rsp_idx, scan_idx;
  logic [CH_W-1:0]         pick_ch, cand;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(TAG_COUNT - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_INIT;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      init_cnt_q     <= '0;
      count_q        <= '0;
      scan_q         <= '0;
      valid_q        <= '0;
      replay_q       <= '0;
      rr_q           <= '0;
      alloc_grant_q  <= '0;
      alloc_tag_q    <= '0;
      replay_tag_q   <= '0;
      replay_ch_q    <= '0;
      error_tag_q    <= '0;
      restart_req_q  <= 1'b0;
      replay_valid_q <= 1'b0;
      pool_ready_q   <= 1'b0;
      error_flag_q   <= 1'b0;
      for (int i = 0; i < int'(TAG_COUNT); i++) owner_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      init_cnt_q     <= init_cnt_d;
      count_q        <= count_d;
      scan_q         <= scan_d;
      valid_q        <= valid_d;
      replay_q       <= replay_d;
      rr_q           <= rr_d;
      alloc_grant_q  <= alloc_grant_d;
      alloc_tag_q    <= alloc_tag_d;
      replay_tag_q   <= replay_tag_d;
      replay_ch_q    <= replay_ch_d;
      error_tag_q    <= error_tag_d;
      restart_req_q  <= restart_req_d;
      replay_valid_q <= replay_valid_d;
      pool_ready_q   <= pool_ready_d;
      error_flag_q   <= error_flag_d;
      owner_q        <= owner_d;
    end
  end

  // Free-list storage needs no reset: INIT refills it before any pop.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    state_d        = state_q;
    fifo_d         = fifo_q;
    owner_d        = owner_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    init_cnt_d     = init_cnt_q;
    scan_d         = scan_q;
    valid_d        = valid_q;
    replay_d       = replay_q;
    rr_d           = rr_q;
    alloc_grant_d  = '0;
    alloc_tag_d    = '0;
    replay_tag_d   = replay_tag_q;
    replay_ch_d    = replay_ch_q;
    replay_valid_d = replay_valid_q;
    error_flag_d   = error_flag_q;
    error_tag_d    = error_tag_q;
    push           = 1'b0;
    push_tag       = '0;
    pop            = 1'b0;
    pop_tag        = fifo_q[rd_ptr_q];
    rsp_idx        = rsp_tag[TAG_W-1:0];
    rsp_ok         = rsp_valid && ({1'b0, rsp_tag} < 9'(TAG_COUNT)) && valid_q[rsp_idx];

    // Round-robin pick, lowest offset from rr_q wins.
    have_req = 1'b0;
    pick_ch  = '0;
    for (int k = int'(NUM_CHANNELS) - 1; k >= 0; k--) begin
      cand = CH_W'((int'(rr_q) + k) % int'(NUM_CHANNELS));
      if (alloc_req[cand]) begin
        have_req = 1'b1;
        pick_ch  = cand;
      end
    end

    // Lowest replay-marked tag at or above the scan position.
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = int'(TAG_COUNT) - 1; i >= 0; i--) begin
      if (replay_q[i] && (9'(i) >= scan_q)) begin
        scan_hit = 1'b1;
        scan_idx = TAG_W'(i);
      end
    end

    if (state_q == ST_INIT) begin
      push       = 1'b1;
      push_tag   = 8'(init_cnt_q);
      init_cnt_d = init_cnt_q + TAG_W'(1);
      if (init_cnt_q == TAG_W'(TAG_COUNT - 1)) state_d = ST_READY;
    end

    if (state_q == ST_FLUSH && (valid_q & ~replay_q) == '0) begin
      state_d = (|replay_q) ? ST_RESTART : ST_READY;
    end

    if (state_q == ST_RESTART && restart_ack) begin
      state_d        = ST_REPLAY;
      scan_d         = '0;
      replay_valid_d = 1'b0;
    end

    // Replay handshake is applied before responses so a new PAGED re-marks.
    if (state_q == ST_REPLAY) begin
      if (replay_valid_q) begin
        if (replay_ready) begin
          replay_d[replay_tag_q[TAG_W-1:0]] = 1'b0;
          scan_d         = 9'(replay_tag_q) + 9'd1;
          replay_valid_d = 1'b0;
        end
      end else if (scan_hit) begin
        replay_valid_d = 1'b1;
        replay_tag_d   = 8'(scan_idx);
        replay_ch_d    = owner_q[scan_idx];
      end
    end

    if (rsp_ok) begin
      case (rsp_code)
        RSP_DONE, RSP_ERROR: begin
          if (!replay_q[rsp_idx]) begin
            push             = 1'b1;
            push_tag         = rsp_tag;
            valid_d[rsp_idx] = 1'b0;
          end
        end
        RSP_PAGED: begin
          replay_d[rsp_idx] = 1'b1;
          if (state_q == ST_READY) state_d = ST_FLUSH;
        end
        RSP_FLUSHED: begin
          if (state_q != ST_READY) replay_d[rsp_idx] = 1'b1;
        end
        default: ;
      endcase
    end

    if (rsp_valid && (!rsp_ok || rsp_code == RSP_ERROR) && !error_flag_q) begin
      error_flag_d = 1'b1;
      error_tag_d  = rsp_tag;
    end

    // A tag re-marked behind the scan point forces another flush round.
    if (state_q == ST_REPLAY && !replay_valid_q && !scan_hit) begin
      state_d = (|replay_d) ? ST_FLUSH : ST_READY;
    end

    if (state_q == ST_READY && count_q != '0 && have_req) begin
      pop                               = 1'b1;
      alloc_grant_d[pick_ch]            = 1'b1;
      alloc_tag_d                       = pop_tag;
      valid_d[pop_tag[TAG_W-1:0]]       = 1'b1;
      owner_d[pop_tag[TAG_W-1:0]]       = pick_ch;
      rr_d = (pick_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : pick_ch + CH_W'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = push_tag;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + 9'(push) - 9'(pop);

    pool_ready_d  = (state_d == ST_READY);
    restart_req_d = (state_d == ST_RESTART);
  end

  assign alloc_grant  = alloc_grant_q;
  assign alloc_tag    = alloc_tag_q;
  assign restart_req  = restart_req_q;
  assign replay_valid = replay_valid_q;
  assign replay_tag   = replay_tag_q;
  assign replay_ch    = replay_ch_q;
  assign pool_ready   = pool_ready_q;
  assign free_count   = count_q;
  assign error_flag   = error_flag_q;
  assign error_tag    = error_tag_q;

endmodule
